// File: rtl/ex_stage.sv
// Execute stage: one-hot ALU, store byte lanes, multiplier operand hand-off, forwarding bus.
// Define EX_ITER_DIV_EN to build the 32-cycle restoring divider; upper 20 bits of id_to_ex_wire are reserved.
module ex_stage (
  input  logic         clk,
  input  logic         resetn,
  output logic         ex_allowin,
  input  logic         id_to_ex_valid,
  input  logic [180:0] id_to_ex_wire,
  input  logic         mem_allowin,
  output logic         ex_to_mem_valid,
  output logic [109:0] ex_to_mem_wire,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [31:0]  mul_src1,
  output logic [31:0]  mul_src2,
  output logic         mul_signed,
  output logic [38:0]  ex_rf_zip
);

  typedef struct packed {
    logic [19:0] rsvd;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
    logic [4:0]  ld_op;
    logic [2:0]  st_op;
    logic [31:0] st_data;
    logic [2:0]  mul_op;
    logic [3:0]  div_op;
  } id_ex_t;

  id_ex_t      pl_q, pl_d;
  logic        ex_valid_q, ex_valid_d;
  logic        ex_ready_go;
  logic        div_pend;
  logic        res_from_div;
  logic [31:0] div_result;
  logic [31:0] alu_res;
  logic        ld_any, st_any, ex_block;

  assign ex_allowin      = ~ex_valid_q | (ex_ready_go & mem_allowin);
  assign ex_to_mem_valid = ex_valid_q & ex_ready_go;

  always_comb begin
    pl_d       = pl_q;
    ex_valid_d = ex_valid_q;
    if (ex_allowin) ex_valid_d = id_to_ex_valid;
    if (id_to_ex_valid & ex_allowin) pl_d = id_ex_t'(id_to_ex_wire);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ex_valid_q <= 1'b0;
    else         ex_valid_q <= ex_valid_d;
  end

  // payload carries no reset; ex_valid_q qualifies every use
  always_ff @(posedge clk) pl_q <= pl_d;

  logic [31:0] s1, s2;
  logic [4:0]  sa;
  assign s1 = pl_q.src1;
  assign s2 = pl_q.src2;
  assign sa = pl_q.src2[4:0];

  always_comb begin
    alu_res = '0;
    if (pl_q.alu_op[0])  alu_res = alu_res | (s1 + s2);
    if (pl_q.alu_op[1])  alu_res = alu_res | (s1 - s2);
    if (pl_q.alu_op[2])  alu_res = alu_res | {31'b0, $signed(s1) < $signed(s2)};
    if (pl_q.alu_op[3])  alu_res = alu_res | {31'b0, s1 < s2};
    if (pl_q.alu_op[4])  alu_res = alu_res | (s1 & s2);
    if (pl_q.alu_op[5])  alu_res = alu_res | ~(s1 | s2);
    if (pl_q.alu_op[6])  alu_res = alu_res | (s1 | s2);
    if (pl_q.alu_op[7])  alu_res = alu_res | (s1 ^ s2);
    if (pl_q.alu_op[8])  alu_res = alu_res | (s1 << sa);
    if (pl_q.alu_op[9])  alu_res = alu_res | (s1 >> sa);
    if (pl_q.alu_op[10]) alu_res = alu_res | $unsigned($signed(s1) >>> sa);
    if (pl_q.alu_op[11]) alu_res = alu_res | s2;
  end

`ifdef EX_ITER_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_st_e;

  div_st_e     st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        negq_q, negq_d, negr_q, negr_d, dvz_q, dvz_d;
  logic        div_any, div_sgn;
  logic [32:0] trial, diff;
  logic [31:0] q_fix, r_fix;

  assign div_any = |pl_q.div_op;
  assign div_sgn = pl_q.div_op[0] | pl_q.div_op[1];
  // restoring step: shift one dividend bit into the partial remainder and try the subtract
  assign trial   = {rem_q, quo_q[31]};
  assign diff    = trial - {1'b0, dvs_q};

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dvz_d  = dvz_q;
    case (st_q)
      IDLE: if (ex_valid_q & div_any) begin
        st_d   = BUSY;
        cnt_d  = '0;
        rem_d  = '0;
        quo_d  = (div_sgn & s1[31]) ? -s1 : s1;
        dvs_d  = (div_sgn & s2[31]) ? -s2 : s2;
        negq_d = div_sgn & (s1[31] ^ s2[31]);
        negr_d = div_sgn & s1[31];
        dvz_d  = (s2 == 32'd0);
      end
      BUSY: begin
        rem_d = diff[32] ? trial[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) st_d = DONE;
      end
      DONE: if (ex_to_mem_valid & mem_allowin) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    quo_q  <= quo_d;
    rem_q  <= rem_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    dvz_q  <= dvz_d;
  end

  // a zero divisor leaves the magnitude quotient all ones; force it so the sign fix cannot flip it
  assign q_fix        = dvz_q ? 32'hFFFF_FFFF : (negq_q ? -quo_q : quo_q);
  assign r_fix        = negr_q ? -rem_q : rem_q;
  assign div_result   = (pl_q.div_op[0] | pl_q.div_op[2]) ? q_fix : r_fix;
  assign res_from_div = div_any;
  assign ex_ready_go  = ~div_any | (st_q == DONE);
  assign div_pend     = div_any & (st_q != DONE);
`else
  logic unused_div;
  assign unused_div   = ^pl_q.div_op;
  assign div_result   = '0;
  assign res_from_div = 1'b0;
  assign ex_ready_go  = 1'b1;
  assign div_pend     = 1'b0;
`endif

  logic unused_rsvd;
  assign unused_rsvd = ^pl_q.rsvd;

  assign ld_any = |pl_q.ld_op;
  assign st_any = |pl_q.st_op;

  assign data_sram_en   = ex_valid_q & ex_ready_go & mem_allowin & (ld_any | st_any);
  assign data_sram_addr = alu_res;

  always_comb begin
    data_sram_we = 4'b0000;
    if (data_sram_en) begin
      if      (pl_q.st_op[0]) data_sram_we = 4'b0001 << alu_res[1:0];
      else if (pl_q.st_op[1]) data_sram_we = alu_res[1] ? 4'b1100 : 4'b0011;
      else if (pl_q.st_op[2]) data_sram_we = 4'b1111;
    end
  end

  always_comb begin
    data_sram_wdata = pl_q.st_data;
    if      (pl_q.st_op[0]) data_sram_wdata = {4{pl_q.st_data[7:0]}};
    else if (pl_q.st_op[1]) data_sram_wdata = {2{pl_q.st_data[15:0]}};
  end

  assign mul_src1   = s1;
  assign mul_src2   = s2;
  assign mul_signed = pl_q.mul_op[1];

  assign ex_to_mem_wire = {pl_q.rf_we, pl_q.rf_waddr, pl_q.pc, alu_res, pl_q.ld_op,
                           |pl_q.mul_op, pl_q.mul_op[1] | pl_q.mul_op[2],
                           res_from_div, div_result};

  // results not yet available to forward: loads, multiplies, unfinished divides
  assign ex_block  = ex_valid_q & (ld_any | (|pl_q.mul_op) | div_pend);
  assign ex_rf_zip = {pl_q.rf_we & ex_valid_q, ex_block, pl_q.rf_waddr, alu_res};

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: ex_allowin  out  1  EX can accept an instruction.
REQ-004 SHALL have: id_to_ex_valid  in  1 ; id_to_ex_wire  in  181  {alu_op[11:0], src1[31:0], src2[31:0], rf_we, rf_waddr[4:0], pc[31:0], ld_op[4:0] (b,bu,h,hu,w), st_op[2:0] (b,h,w), st_data[31:0], mul_op[2:0] (mul,mulh,mulhu), div_op[3:0] (div,mod,divu,modu)}.
REQ-005 SHALL have: mem_allowin  in  1 ; ex_to_mem_valid  out  1 ; ex_to_mem_wire  out  110  {rf_we, rf_waddr, pc, alu_result, ld_op[4:0], res_from_mul, mul_h, res_from_div, div_result[31:0]}.
REQ-006 SHALL have: data_sram_en  out  1 ; data_sram_we  out  4 ; data_sram_addr  out  32 ; data_sram_wdata  out  32.
REQ-007 SHALL have: mul_src1, mul_src2  out  32 each ; mul_signed  out  1  operands to external multiplier.
REQ-008 SHALL have: ex_rf_zip  out  39  {rf_we&ex_valid, ex_block, rf_waddr, alu_result} forwarding bus.

Function
REQ-009 SHALL latch id_to_ex_wire when id_to_ex_valid & ex_allowin; ex_valid <= id_to_ex_valid when ex_allowin.
REQ-010 SHALL drive ex_allowin = ~ex_valid | ex_ready_go & mem_allowin; ex_to_mem_valid = ex_valid & ex_ready_go.
REQ-011 ALU SHALL implement one-hot add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui; shift amount src2[4:0]; lui result = src2; result combinational in the same cycle.
REQ-012 data_sram_en SHALL = ex_valid & ex_ready_go & mem_allowin & (any ld_op | any st_op); addr = alu_result unchanged.
REQ-013 data_sram_we SHALL be 0 unless en & store: st_b -> 4'b0001 << addr[1:0]; st_h -> addr[1] ? 1100 : 0011; st_w -> 1111.
REQ-014 data_sram_wdata SHALL be st_data[7:0] replicated x4 (st_b), st_data[15:0] x2 (st_h), st_data (st_w).
REQ-015 mul_src1/2 SHALL be src1/src2; mul_signed = mul_op.mulh; res_from_mul = any mul_op; mul_h = mulh | mulhu.
REQ-016 Divider FSM SHALL have states IDLE, BUSY, DONE; IDLE->BUSY when ex_valid & any div_op; BUSY holds 32 cycles (5-bit counter, one restoring quotient bit per cycle) -> DONE; DONE->IDLE on ex_to_mem_valid & mem_allowin.
REQ-017 ex_ready_go SHALL = 1 for non-divide instructions, = (state==DONE) for divides; instruction entering EX at cycle T has ready_go first at T+33.
REQ-018 Signed divide SHALL operate on magnitudes; quotient negated if operand signs differ, remainder takes dividend sign.
REQ-019 Divisor zero SHALL yield quotient 0xFFFFFFFF, remainder = dividend, same 33-cycle latency.
REQ-020 0x80000000 div -1 SHALL yield quotient 0x80000000, remainder 0.
REQ-021 div_result SHALL be quotient for div/divu, remainder for mod/modu; res_from_div = any div_op; result held stable through DONE while mem_allowin low.
REQ-022 ex_block SHALL = ex_valid & (any ld_op | any mul_op | (any div_op & state!=DONE)).

Reset
REQ-023 On resetn low SHALL immediately clear ex_valid, FSM to IDLE, counter 0; ex_to_mem_valid, data_sram_en, data_sram_we, ex_rf_zip[38:37] all 0.
REQ-024 Reset mid-divide SHALL abandon the operation; no stale result after release.
REQ-025 Payload register SHALL NOT be reset.

Configuration
REQ-026 With EX_ITER_DIV_EN defined SHALL include the divider of REQ-016..021.
REQ-027 Without EX_ITER_DIV_EN SHALL omit the divider: div_op ignored, res_from_div = 0, div_result = 0, ex_ready_go = 1 always.

Verification
REQ-028 add src1=5 src2=7, mem_allowin=1 -> ex_to_mem_valid next cycle, alu_result=12, data_sram_en=0.
REQ-029 st_b addr 0x1003 st_data 0xAB -> en=1, we=1000, wdata=0xABABABAB.
REQ-030 div 0xFFFFFFF9 / 2 -> ex_allowin low 33 cycles, div_result 0xFFFFFFFD; mod gives 0xFFFFFFFF.
REQ-031 divu 10 / 0 -> quotient 0xFFFFFFFF; modu -> 10; DONE held while mem_allowin=0 for 5 cycles.
REQ-032 resetn low at BUSY cycle 10 -> outputs 0 immediately; next add completes in 1 cycle.
REQ-033 ld_w to r4 in EX -> ex_rf_zip[38]=1, ex_block=1, waddr=4.
